// File: rtl/sync_fifo_core_pkg.sv
// sync_fifo_core_pkg: operation encoding shared by the FIFO core
package sync_fifo_core_pkg;
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;
  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: storage array with one write port and one registered read port
module sync_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  // storage is never reset; only written entries are ever read back
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  // read register holds its value whenever no read is accepted
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with registered read data, flags and counters
module sync_fifo_core
  import sync_fifo_core_pkg::*;
#(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rstb,
  input  logic                  fifo_wren,
  input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_rden,
  output logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [FIFO_PTR:0]     fifo_room_avail,
  output logic [FIFO_PTR:0]     fifo_data_avail
);
  localparam logic [FIFO_PTR:0]   DEPTH_C = (FIFO_PTR+1)'(FIFO_DEPTH);
  localparam logic [FIFO_PTR:0]   CNT_ONE = (FIFO_PTR+1)'(1);
  localparam logic [FIFO_PTR-1:0] PTR_ONE = FIFO_PTR'(1);
  if (FIFO_DEPTH != 2**FIFO_PTR) begin : g_depth_chk
    $error("sync_fifo_core: FIFO_DEPTH must equal 2**FIFO_PTR");
  end
  logic [FIFO_PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR:0]   count_q, count_d, room_q, room_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                wr_acc, rd_acc;
  fifo_op_e            op;
  // flags come from registers, so acceptance never depends on same-cycle outputs
  assign wr_acc = fifo_wren && !full_q;
  assign rd_acc = fifo_rden && !empty_q;
  // next-state: pointers advance per accepted op, flags derive from the next count
  always_comb begin
    op       = fifo_op(wr_acc, rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = (op == OP_WR) ? count_q + CNT_ONE : (op == OP_RD) ? count_q - CNT_ONE : count_q;
    room_d   = DEPTH_C - count_d;
    full_d   = count_d == DEPTH_C;
    empty_d  = count_d == '0;
  end
  // state and output registers; reset discards all contents at once
  always_ff @(posedge fifo_clk or negedge fifo_rstb)
    if (!fifo_rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      room_q   <= DEPTH_C;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      room_q   <= room_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  sync_fifo_mem #(
    .ADDR_W(FIFO_PTR),
    .DATA_W(FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk_i  (fifo_clk),
    .rst_ni (fifo_rstb),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(fifo_wrdata),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q),
    .rdata_o(fifo_rddata)
  );
  assign fifo_full       = full_q;
  assign fifo_empty      = empty_q;
  assign fifo_room_avail = room_q;
  assign fifo_data_avail = count_q;
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: vector table plus queue scoreboard for the FIFO core
module tb_sync_fifo_core;
  logic       fifo_clk, fifo_rstb, fifo_wren, fifo_rden;
  logic [7:0] fifo_wrdata, fifo_rddata;
  logic       fifo_full, fifo_empty;
  logic [4:0] fifo_room_avail, fifo_data_avail;
  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_rd;
  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic [7:0] rd;
  } vec_t;
  vec_t tv[8];

  sync_fifo_core #(.FIFO_PTR(4), .FIFO_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .fifo_clk       (fifo_clk),
    .fifo_rstb      (fifo_rstb),
    .fifo_wren      (fifo_wren),
    .fifo_wrdata    (fifo_wrdata),
    .fifo_rden      (fifo_rden),
    .fifo_rddata    (fifo_rddata),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_room_avail(fifo_room_avail),
    .fifo_data_avail(fifo_data_avail)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input int cnt, input logic [7:0] rd);
    chk({nm, ".data_avail"}, 32'(fifo_data_avail), 32'(cnt));
    chk({nm, ".room_avail"}, 32'(fifo_room_avail), 32'(16 - cnt));
    chk({nm, ".full"}, 32'(fifo_full), 32'(cnt == 16));
    chk({nm, ".empty"}, 32'(fifo_empty), 32'(cnt == 0));
    chk({nm, ".rddata"}, 32'(fifo_rddata), 32'(rd));
  endtask

  task automatic step(input string nm, input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    fifo_wren = w;
    fifo_rden = r;
    fifo_wrdata = d;
    wa = w && (sb.size() < 16);
    ra = r && (sb.size() > 0);
    @(posedge fifo_clk);
    #3;
    fifo_wren = 1'b0;
    fifo_rden = 1'b0;
    if (ra) exp_rd = sb.pop_front();
    if (wa) sb.push_back(d);
    chk_state(nm, sb.size(), exp_rd);
  endtask

  task automatic fill_drain(input string nm, input int gap, input bit rnd_gap);
    for (int i = 0; i < 256; i++) begin
      step({nm, ".wr"}, 1'b1, 1'b0, 8'($urandom));
      repeat (rnd_gap ? $urandom_range(0, 4) : gap) step({nm, ".wgap"}, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      step({nm, ".rd"}, 1'b0, 1'b1, 8'h00);
      repeat (rnd_gap ? $urandom_range(0, 4) : gap) step({nm, ".rgap"}, 1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    fifo_rstb = 1'b0;
    fifo_wren = 1'b0;
    fifo_rden = 1'b0;
    fifo_wrdata = 8'h00;
    exp_rd = 8'h00;
    repeat (5) @(posedge fifo_clk);
    #3;
    chk_state("reset", 0, 8'h00);
    fifo_rstb = 1'b1;
    tv[0] = '{w: 1'b1, r: 1'b0, d: 8'hA1, cnt: 1, rd: 8'h00};
    tv[1] = '{w: 1'b1, r: 1'b0, d: 8'hB2, cnt: 2, rd: 8'h00};
    tv[2] = '{w: 1'b0, r: 1'b1, d: 8'h00, cnt: 1, rd: 8'hA1};
    tv[3] = '{w: 1'b1, r: 1'b1, d: 8'hC3, cnt: 1, rd: 8'hB2};
    tv[4] = '{w: 1'b0, r: 1'b1, d: 8'h00, cnt: 0, rd: 8'hC3};
    tv[5] = '{w: 1'b0, r: 1'b1, d: 8'h00, cnt: 0, rd: 8'hC3};
    tv[6] = '{w: 1'b1, r: 1'b1, d: 8'hD4, cnt: 1, rd: 8'hC3};
    tv[7] = '{w: 1'b0, r: 1'b1, d: 8'h00, cnt: 0, rd: 8'hD4};
    for (int i = 0; i < 8; i++) begin
      fifo_wren = tv[i].w;
      fifo_rden = tv[i].r;
      fifo_wrdata = tv[i].d;
      @(posedge fifo_clk);
      #3;
      fifo_wren = 1'b0;
      fifo_rden = 1'b0;
      chk_state($sformatf("vec%0d", i), tv[i].cnt, tv[i].rd);
    end
    exp_rd = tv[7].rd;
    fill_drain("fill_rnd", 0, 1'b1);
    for (int g = 0; g <= 4; g++)
      repeat (2) fill_drain($sformatf("wrap_g%0d", g), g, 1'b0);
    repeat (8) step("pre8", 1'b1, 1'b0, 8'($urandom));
    step("both_at8", 1'b1, 1'b1, 8'h5A);
    repeat (8) step("pre16", 1'b1, 1'b0, 8'($urandom));
    step("both_full", 1'b1, 1'b1, 8'hEE);
    repeat (16) step("drain", 1'b0, 1'b1, 8'h00);
    step("both_empty", 1'b1, 1'b1, 8'h77);
    step("after_empty", 1'b0, 1'b1, 8'h00);
    repeat (5) step("pre_rst", 1'b1, 1'b0, 8'($urandom));
    #2;
    fifo_rstb = 1'b0;
    #1;
    sb.delete();
    exp_rd = 8'h00;
    chk_state("async_rst", 0, 8'h00);
    @(posedge fifo_clk);
    #3;
    fifo_rstb = 1'b1;
    step("post_rst", 1'b0, 1'b1, 8'h00);
    step("post_rst_wr", 1'b1, 1'b0, 8'h3C);
    step("post_rst_rd", 1'b0, 1'b1, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
